// File: rtl/stopwatch_lap_timer.sv
// ----------------------------------------------------------------------------
// stopwatch_lap_timer
// Stopwatch core: run-control FSM, tick divider and a multi-digit BCD counter.
// Supports MM:SS.hh sexagesimal digits, lap freeze, a preloaded countdown with
// a done flag and a one-cycle overflow pulse on up-count wrap.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start/lap/clear button levels (synchronised); each acts on its rising edge
//   count_down      direction, latched on the start edge that leaves IDLE/PAUSE
//   load/load_value one-cycle preload strobe (IDLE only) and BCD preload value
//   digits          displayed BCD value (lap register in LAP, else live count)
//   running         high in RUN and LAP
//   lap_active      high in LAP
//   done            high in DONE
//   overflow        one-cycle pulse when the up count wraps to zero
// ----------------------------------------------------------------------------
module stopwatch_lap_timer #(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned SEXAGESIMAL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    lap,
    input  logic                    clear,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned CNT_W = 4 * NUM_DIGITS;
    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Highest value a digit counts to before wrapping.
    function automatic logic [3:0] digit_limit(input int unsigned idx);
        if ((SEXAGESIMAL != 0) && ((idx == 32'd3) || (idx == 32'd5))) begin
            return 4'd5;
        end
        return 4'd9;
    endfunction

    // Ripple BCD increment; MSB of the result is the carry out of the top digit.
    // Digits at or above their limit wrap to 0 and carry.
    function automatic logic [CNT_W:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             c;
        logic [3:0]       d;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d >= digit_limit(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Ripple BCD decrement; a zero digit borrows and reloads with its limit.
    // Out-of-range digits simply decrement.
    function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             b;
        logic [3:0]       d;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = digit_limit(i);
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic [CNT_W-1:0]   lap_reg_q,    lap_reg_d;
    logic [DIV_W-1:0]   div_q,        div_d;
    logic               dir_q,        dir_d;
    logic               start_prev_q, start_prev_d;
    logic               lap_prev_q,   lap_prev_d;
    logic               clear_prev_q, clear_prev_d;
    logic [CNT_W-1:0]   digits_q,     digits_d;
    logic               running_q,    running_d;
    logic               lap_active_q, lap_active_d;
    logic               done_q,       done_d;
    logic               overflow_q,   overflow_d;

    logic               start_edge;
    logic               lap_edge;
    logic               clear_edge;
    logic               active;
    logic               tick;
    logic [CNT_W:0]     inc_res;
    logic [CNT_W-1:0]   dec_res;

    assign start_edge = start & ~start_prev_q;
    assign lap_edge   = lap   & ~lap_prev_q;
    assign clear_edge = clear & ~clear_prev_q;

    // Next-state, counter, divider and output computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_reg_d    = lap_reg_q;
        dir_d        = dir_q;
        div_d        = '0;
        overflow_d   = 1'b0;
        start_prev_d = start;
        lap_prev_d   = lap;
        clear_prev_d = clear;

        active  = (state_q == S_RUN) || (state_q == S_LAP);
        tick    = active && (div_q == DIV_LAST);
        inc_res = bcd_inc(count_q);
        dec_res = bcd_dec(count_q);

        // The tick update is applied first; edge-driven transitions follow.
        if (tick) begin
            if (dir_q) begin
                count_d = dec_res;
            end else begin
                count_d    = inc_res[CNT_W-1:0];
                overflow_d = inc_res[CNT_W];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (clear_edge) begin
                    count_d = '0;
                end else if (start_edge) begin
                    dir_d   = count_down;
                    state_d = (count_down && (count_q == '0)) ? S_DONE : S_RUN;
                end else if (load) begin
                    count_d = load_value;
                end
            end
            S_RUN: begin
                if (start_edge) begin
                    state_d = S_PAUSE;
                end else if (lap_edge) begin
                    state_d   = S_LAP;
                    lap_reg_d = count_q;
                end
            end
            S_LAP: begin
                if (start_edge) begin
                    state_d = S_PAUSE;
                end else if (lap_edge) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (clear_edge) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (start_edge) begin
                    dir_d   = count_down;
                    state_d = (count_down && (count_q == '0)) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                count_d = '0;
                if (clear_edge || start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A countdown tick that reaches zero ends the run regardless of edges.
        if (tick && dir_q && (dec_res == '0)) begin
            state_d = S_DONE;
        end

        // Divider only runs while staying in RUN/LAP, so a pause drops any partial tick.
        if (active && ((state_d == S_RUN) || (state_d == S_LAP))) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        digits_d     = (state_d == S_LAP) ? lap_reg_d : count_d;
        running_d    = (state_d == S_RUN) || (state_d == S_LAP);
        lap_active_d = (state_d == S_LAP);
        done_d       = (state_d == S_DONE);
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            lap_reg_q    <= '0;
            div_q        <= '0;
            dir_q        <= 1'b0;
            // Held buttons must not produce an edge right after reset.
            start_prev_q <= 1'b1;
            lap_prev_q   <= 1'b1;
            clear_prev_q <= 1'b1;
            digits_q     <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_reg_q    <= lap_reg_d;
            div_q        <= div_d;
            dir_q        <= dir_d;
            start_prev_q <= start_prev_d;
            lap_prev_q   <= lap_prev_d;
            clear_prev_q <= clear_prev_d;
            digits_q     <= digits_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign digits     = digits_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_lap_timer
// Bench for stopwatch_lap_timer with NUM_DIGITS=6, TICK_DIV=4, SEXAGESIMAL=1.
// Expected output vectors {digits, running, lap_active, done, overflow} are
// queued as stimulus is applied and popped when the DUT output is sampled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_lap_timer;

    localparam int unsigned ND = 6;

    logic            clk;
    logic            rst;
    logic            start;
    logic            lap;
    logic            clear;
    logic            count_down;
    logic            load;
    logic [4*ND-1:0] load_value;
    logic [4*ND-1:0] digits;
    logic            running;
    logic            lap_active;
    logic            done;
    logic            overflow;

    logic [4*ND+3:0] obs;
    assign obs = {digits, running, lap_active, done, overflow};

    typedef struct {
        string           name;
        logic [4*ND+3:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks;
    int   errors;

    stopwatch_lap_timer #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (4),
        .SEXAGESIMAL(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lap       (lap),
        .clear     (clear),
        .count_down(count_down),
        .load      (load),
        .load_value(load_value),
        .digits    (digits),
        .running   (running),
        .lap_active(lap_active),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; lap = 1'b0; clear = 1'b0;
        count_down = 1'b0; load = 1'b0; load_value = '0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic do_load(input logic [4*ND-1:0] v);
        load_value = v;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back('{name:"reset_state", val:{24'h000000, 4'b0000}});
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_up_count();
        do_reset();
        start = 1'b1;
        exp_q.push_back('{name:"up_start", val:{24'h000000, 4'b1000}});
        cyc(1);
        start = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"up_pre_tick", val:{24'h000000, 4'b1000}});
        cyc(3);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"up_first_tick", val:{24'h000001, 4'b1000}});
        cyc(1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"up_100_cycles", val:{24'h000025, 4'b1000}});
        cyc(96);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_overflow();
        do_reset();
        exp_q.push_back('{name:"ovf_load", val:{24'h595999, 4'b0000}});
        do_load(24'h595999);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        exp_q.push_back('{name:"ovf_before", val:{24'h595999, 4'b1000}});
        cyc(3);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"ovf_wrap", val:{24'h000000, 4'b1001}});
        cyc(1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"ovf_one_cycle", val:{24'h000000, 4'b1000}});
        cyc(1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end

        do_reset();
        do_load(24'h005999);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        exp_q.push_back('{name:"sexa_carry", val:{24'h010000, 4'b1000}});
        cyc(4);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end

        // Out-of-range digit is loaded as-is and wraps with carry on increment.
        do_reset();
        exp_q.push_back('{name:"oor_load", val:{24'h00070a, 4'b0000}});
        do_load(24'h00070a);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        exp_q.push_back('{name:"oor_inc", val:{24'h000710, 4'b1000}});
        cyc(4);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_countdown();
        do_reset();
        do_load(24'h000003);
        count_down = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        count_down = 1'b0;
        exp_q.push_back('{name:"down_two_ticks", val:{24'h000001, 4'b1000}});
        cyc(11);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"down_done", val:{24'h000000, 4'b0010}});
        cyc(1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"down_hold", val:{24'h000000, 4'b0010}});
        cyc(40);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        clear = 1'b1;
        exp_q.push_back('{name:"down_clear_idle", val:{24'h000000, 4'b0000}});
        cyc(1);
        clear = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end

        // Start with zero count in the down direction goes straight to DONE.
        do_reset();
        count_down = 1'b1;
        start = 1'b1;
        exp_q.push_back('{name:"down_zero_start", val:{24'h000000, 4'b0010}});
        cyc(1);
        start = 1'b0;
        count_down = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_lap();
        do_reset();
        do_load(24'h000012);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        lap = 1'b1;
        exp_q.push_back('{name:"lap_enter", val:{24'h000012, 4'b1100}});
        cyc(1);
        lap = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"lap_frozen", val:{24'h000012, 4'b1100}});
        cyc(31);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        lap = 1'b1;
        exp_q.push_back('{name:"lap_exit_live", val:{24'h000020, 4'b1000}});
        cyc(1);
        lap = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        start = 1'b1;
        exp_q.push_back('{name:"lap_pause", val:{24'h000020, 4'b0000}});
        cyc(1);
        start = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        clear = 1'b1;
        exp_q.push_back('{name:"lap_clear", val:{24'h000000, 4'b0000}});
        cyc(1);
        clear = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_same_cycle_edges();
        do_reset();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        start = 1'b1;
        lap = 1'b1;
        exp_q.push_back('{name:"start_lap_pause", val:{24'h000001, 4'b0000}});
        cyc(1);
        start = 1'b0;
        lap = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        cyc(1);
        clear = 1'b1;
        start = 1'b1;
        exp_q.push_back('{name:"clear_start_idle", val:{24'h000000, 4'b0000}});
        cyc(1);
        clear = 1'b0;
        start = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"idle_stays", val:{24'h000000, 4'b0000}});
        cyc(10);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_tick_and_start();
        do_reset();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        start = 1'b1;
        exp_q.push_back('{name:"tick_start_pause", val:{24'h000001, 4'b0000}});
        cyc(1);
        start = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"pause_holds", val:{24'h000001, 4'b0000}});
        cyc(8);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        exp_q.push_back('{name:"resume_pre_tick", val:{24'h000001, 4'b1000}});
        cyc(3);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        exp_q.push_back('{name:"resume_full_tick", val:{24'h000002, 4'b1000}});
        cyc(1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
    endtask

    task automatic test_reset_behaviour();
        rst = 1'b1;
        start = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_q.push_back('{name:"held_start_no_edge", val:{24'h000000, 4'b0000}});
        cyc(5);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        exp_q.push_back('{name:"run_before_rst", val:{24'h000005, 4'b1000}});
        cyc(20);
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        #2;
        rst = 1'b1;
        exp_q.push_back('{name:"async_rst", val:{24'h000000, 4'b0000}});
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.val); end
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_up_count();
        test_overflow();
        test_countdown();
        test_lap();
        test_same_cycle_edges();
        test_tick_and_start();
        test_reset_behaviour();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised next-generation stopwatch core. It combines the run-control FSM, the tick divider and a multi-digit BCD time counter in one block. New relative to the current stopwatch: configurable digit count and tick rate, MM:SS.hh sexagesimal wrap, lap freeze, preloaded countdown with a done flag, and an overflow pulse. It drives the per-digit seven-segment decoders in the top level.

Parameters:
NUM_DIGITS, 6, number of BCD digits (4..8); digit 0 is least significant.
TICK_DIV, 500000, clk cycles per increment of digit 0 (100 Hz at 50 MHz); must be at least 2.
SEXAGESIMAL, 1, 1: digits 3 and 5 count 0-5 (seconds/minutes tens); 0: all digits 0-9.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  run/pause button level, already synchronised; acts on rising edge
lap  in  1  lap button level; acts on rising edge
clear  in  1  clear button level; acts on rising edge
count_down  in  1  direction: 0 up, 1 down; sampled only on the start edge that leaves IDLE/PAUSE
load  in  1  one-cycle strobe: load load_value; honoured in IDLE only
load_value  in  4*NUM_DIGITS  BCD preload, digit i at [4i+3:4i]
digits  out  4*NUM_DIGITS  displayed BCD value, same packing as load_value
running  out  1  high in RUN and LAP
lap_active  out  1  high in LAP
done  out  1  high in DONE
overflow  out  1  one-cycle pulse on up-count wrap

Behaviour:
- Edge detect: one previous-value register per button. These registers reset to 1, so a button held through reset produces no edge. Edges are acted on in the same cycle they are detected.
- Priority for same-cycle edges: clear > start > lap. load is ignored in any cycle with a clear or start edge.
- Reset values: count = 0, lap register = 0, divider = 0, state = IDLE, dir = up. All outputs are 0.
- States and transitions:
  IDLE: start edge -> RUN and latch dir from count_down. load -> count = load_value. clear -> count = 0.
  RUN: start edge -> PAUSE. lap edge -> LAP and capture count into the lap register.
  LAP: count keeps advancing. digits show the lap register. lap edge -> RUN. start edge -> PAUSE, and the display returns to live count.
  PAUSE: start edge -> RUN and re-latch dir. clear edge -> IDLE with count = 0.
  DONE: count holds 0. clear edge or start edge -> IDLE.
- digits = lap register in LAP, live count in every other state.
- Divider: counts only in RUN/LAP and is forced to 0 in all other states. A tick is asserted when divider = TICK_DIV-1; the divider then returns to 0. The first tick therefore occurs exactly TICK_DIV cycles after the start edge. Pause preserves no partial tick.
- Counting on tick, up direction:
  - BCD ripple increment. Each digit wraps at its limit: 9, or 5 for digits 3/5 when SEXAGESIMAL=1. The carry propagates to the next digit.
  - When all digits are at their limit, the count wraps to 0 and overflow pulses for one cycle. Counting continues.
- Counting on tick, down direction:
  - BCD ripple decrement. A digit at 0 borrows and reloads with its limit.
  - A tick that makes the count 0 moves the state to DONE on that edge.
  - A start edge into RUN with the count already 0 and dir = down goes directly to DONE.
- load_value digits above their limit are loaded unchanged. Counting resolves them: an increment past an out-of-range digit wraps that digit to 0 with carry; a decrement simply decrements. No other checking is done.
- Tick and edge in the same cycle: the count update from the tick is applied, then the state transition (e.g. a start edge with a tick in RUN gives PAUSE with the incremented count).
- Lap edge and tick in the same cycle: the lap register captures the pre-increment count.
- Asynchronous rst at any time returns every register to its reset value. No partial state survives.

Test Plan:
- TICK_DIV=4, reset, start edge at cycle 0, up count -> digits = 1 after 4 cycles and 25 after 100 cycles. running = 1 throughout.
- Up count from preload 59:59.99 (load in IDLE, then start) -> after one tick digits = 0 and overflow is high for exactly one cycle. With SEXAGESIMAL=1, 00:59.99 goes to 01:00.00.
- Load 00:00.03, count_down = 1, start -> after 3 ticks digits = 0, done = 1, running = 0. A further 10 ticks leave the count unchanged. A clear edge gives IDLE.
- RUN at count 12, lap edge -> digits hold 12 while the internal count reaches 20. A second lap edge shows live 20. A start edge followed by a clear edge gives digits 0 and state IDLE.
- Same cycle start + lap edges in RUN -> PAUSE with lap_active = 0. Clear + start in PAUSE -> IDLE with count 0.
- start held high through rst deassertion -> no transition. Assert rst mid-RUN -> all outputs 0 immediately, asynchronously.
